calculator_multi: RTL and testbench
===================================

Name: calculator_multi

Overview:
- Parametrised successor to the 4-slider calculator: NUM_DIGITS-digit BCD two-operand add/subtract calculator.
- Per-digit increment sliders, debounced clear/enter buttons, overflow and negative flags.
- Multiplexed active-low 7-segment display.
- Sits at board top level between raw switch/button pins and the 7-seg connector.

Parameters:
- NUM_DIGITS, 4: number of BCD digits per operand and per display (2..8).
- REFRESH_OVERFLOW, 100000: clk cycles each display digit is lit.
- DB_OVERFLOW, 50000: consecutive stable cycles required to accept a button change (>=1).
- SLIDER_OVERFLOW, 25000000: clk cycles of a held slider per digit increment (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- button_clr_undeb  in  1  raw clear button.
- button_ent_undeb  in  1  raw enter button.
- sld_inc  in  NUM_DIGITS  raw per-digit increment sliders; bit i = digit i, 0 = least significant.
- sld_arith  in  1  operation: 0 = add, 1 = subtract.
- digit_select  out  NUM_DIGITS  active-low one-hot digit enable.
- led_select  out  7  active-low segments {g,f,e,d,c,b,a}.
- neg  out  1  result negative (RESULT state only).
- ovf  out  1  add overflow (RESULT state only).
- calc_state  out  2  current FSM state (debug/verification).

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state ENTER_A; A = B = R = 0; neg = ovf = 0.
  - Display index 0; digit_select = ~1; led_select = 7'b1000000 ('0').
  - All sync, debounce and slider counters = 0.
- Input conditioning:
  - Every raw input passes a 2-flop synchroniser.
  - Buttons: the debounced level updates only after the synchronised input differs from it for DB_OVERFLOW consecutive cycles.
  - A press is a rising edge of the debounced level: 1-cycle pulse, 2 + DB_OVERFLOW + 1 cycles after the raw edge.
- Digit entry:
  - One shared counter runs while any synchronised sld_inc bit is high; it clears when all are low.
  - When the counter reaches SLIDER_OVERFLOW-1, every digit whose slider is high increments (9 wraps to 0), and the counter resets to 0.
  - Entry targets A in ENTER_A and B in ENTER_B; sliders are ignored in RESULT.
- FSM (calc_state encoding ENTER_A = 0, ENTER_B = 1, RESULT = 2):
  - ENTER_A + enter -> ENTER_B; A holds, B cleared to 0.
  - ENTER_B + enter -> RESULT.
  - RESULT + enter -> ENTER_A with A = R magnitude (chaining); B = 0; neg/ovf cleared.
  - Clear in any state -> ENTER_A; A = B = R = 0; flags cleared.
  - Clear has priority over a simultaneous enter.
- Arithmetic (unsigned BCD, registered, 1-cycle latency):
  - Add: R = (A + B) mod 10^N; ovf = carry out.
  - Subtract: A >= B gives R = A - B, neg = 0; A < B gives R = B - A, neg = 1; ovf = 0.
  - In RESULT, R/neg/ovf recompute every cycle from the current synchronised sld_arith, so toggling the operation updates the display 1 cycle after sync.
  - neg and ovf read 0 outside RESULT.
- Display:
  - Shows A, B or R by state.
  - Refresh counter wraps at REFRESH_OVERFLOW-1, then the digit index advances and wraps at NUM_DIGITS-1.
  - digit_select and led_select are registered, change in the same cycle, and always represent the same digit.
  - Leading zeros are shown. Non-BCD values cannot occur.

Decomposition:
- Package calc_pkg:
  - state_t enum (ENTER_A, ENTER_B, RESULT).
  - op_t (OP_ADD, OP_SUB).
  - 7-seg constant array SEG_LUT[0:9] (active-low).
  - Function bcd_to_seg.
- Sub-module calc_debouncer (synchroniser + debounce + rising-edge pulse), instantiated twice.
- BCD add/subtract is an always_comb ripple over digits inside the top module.

Test Plan (NUM_DIGITS=4, REFRESH=10, DB=1, SLIDER=3):
- Reset low 2 cycles, release -> calc_state = 0, digit_select = 4'b1110, led_select = 7'b1000000, neg = ovf = 0.
- sld_inc[0] high for 2 + 12 cycles -> digit0 of A = 4. Hold for 30 cycles total -> A digit0 wraps: 10 increments return it to its start value.
- A = 0042, enter, B = 0017, enter, sld_arith = 0 -> R = 0059. Toggle sld_arith = 1 -> R = 0025 within 3 cycles, neg = 0.
- A = 0017, B = 0042, subtract -> R = 0025, neg = 1. Enter -> ENTER_A with A = 0025, neg = 0.
- A = 9999, B = 0001, add -> R = 0000, ovf = 1.
- Clear and enter pressed the same cycle in ENTER_B -> ENTER_A, A = B = 0. Reset asserted mid slider-hold -> all state zero immediately, no increment after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types, state encoding and 7-segment decode for the multi-digit BCD calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        RESULT  = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Active-low segments {g,f,e,d,c,b,a} for BCD digits 0..9.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) seg = SEG_LUT[i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/calc_debouncer.sv
// Two-flop synchroniser, stable-count debounce and one-cycle rising-edge press pulse.
module calc_debouncer #(
    parameter int DB_OVERFLOW = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic press_o
);

    localparam int CW = (DB_OVERFLOW > 1) ? $clog2(DB_OVERFLOW) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_OVERFLOW - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d1_q;
    logic          press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw_i};
            level_d1_q <= level_q;
            press_q    <= level_q & ~level_d1_q;
            // Level follows the input only after it has differed for DB_OVERFLOW cycles in a row.
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calculator_multi.sv
// NUM_DIGITS-digit BCD add/subtract calculator with slider entry and a multiplexed 7-seg display.
module calculator_multi
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_OVERFLOW = 100000,
    parameter int DB_OVERFLOW      = 50000,
    parameter int SLIDER_OVERFLOW  = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_clr_undeb,
    input  logic                  button_ent_undeb,
    input  logic [NUM_DIGITS-1:0] sld_inc,
    input  logic                  sld_arith,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic [6:0]            led_select,
    output logic                  neg,
    output logic                  ovf,
    output logic [1:0]            calc_state
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int SW = (SLIDER_OVERFLOW > 1) ? $clog2(SLIDER_OVERFLOW) : 1;
    localparam int RW = (REFRESH_OVERFLOW > 1) ? $clog2(REFRESH_OVERFLOW) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] SLD_MAX = SW'(SLIDER_OVERFLOW - 1);
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_OVERFLOW - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic clr_press, ent_press;

    calc_debouncer #(.DB_OVERFLOW(DB_OVERFLOW)) u_db_clr (
        .clk(clk), .rst_n(reset), .raw_i(button_clr_undeb), .press_o(clr_press)
    );
    calc_debouncer #(.DB_OVERFLOW(DB_OVERFLOW)) u_db_ent (
        .clk(clk), .rst_n(reset), .raw_i(button_ent_undeb), .press_o(ent_press)
    );

    logic [NUM_DIGITS-1:0] sld_s1_q, sld_q;
    logic                  arith_s1_q, arith_q;
    logic [SW-1:0]         sld_cnt_q;
    logic                  sld_tick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sld_s1_q   <= '0;
            sld_q      <= '0;
            arith_s1_q <= 1'b0;
            arith_q    <= 1'b0;
            sld_cnt_q  <= '0;
        end else begin
            sld_s1_q   <= sld_inc;
            sld_q      <= sld_s1_q;
            arith_s1_q <= sld_arith;
            arith_q    <= arith_s1_q;
            if (!(|sld_q) || sld_tick_d) sld_cnt_q <= '0;
            else                         sld_cnt_q <= sld_cnt_q + 1'b1;
        end
    end

    assign sld_tick_d = (|sld_q) && (sld_cnt_q == SLD_MAX);

    state_t         state_q;
    logic [W-1:0]   a_q, b_q, r_q;
    logic           neg_q, ovf_q;

    // Per-digit increment with 9 -> 0 wrap; digits without a held slider pass through.
    logic [W-1:0] a_inc_d, b_inc_d;
    always_comb begin
        a_inc_d = a_q;
        b_inc_d = b_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sld_q[i]) begin
                a_inc_d[4*i +: 4] = (a_q[4*i +: 4] == 4'd9) ? 4'd0 : a_q[4*i +: 4] + 4'd1;
                b_inc_d[4*i +: 4] = (b_q[4*i +: 4] == 4'd9) ? 4'd0 : b_q[4*i +: 4] + 4'd1;
            end
        end
    end

    // Ripple BCD add, A-B and B-A; the final A-B borrow picks the magnitude for subtract.
    op_t          op_d;
    logic [W-1:0] sum_d, dab_d, dba_d, res_d;
    logic         carry_d, br_ab_d, br_ba_d, res_neg_d, res_ovf_d;
    logic [4:0]   t_add, t_ab, t_ba;

    assign op_d = op_t'(arith_q);

    always_comb begin
        sum_d   = '0;
        dab_d   = '0;
        dba_d   = '0;
        carry_d = 1'b0;
        br_ab_d = 1'b0;
        br_ba_d = 1'b0;
        t_add   = '0;
        t_ab    = '0;
        t_ba    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            t_add = {1'b0, a_q[4*i +: 4]} + {1'b0, b_q[4*i +: 4]} + {4'b0, carry_d};
            carry_d = (t_add > 5'd9);
            sum_d[4*i +: 4] = carry_d ? 4'(t_add - 5'd10) : t_add[3:0];

            t_ab = {1'b0, a_q[4*i +: 4]} - {1'b0, b_q[4*i +: 4]} - {4'b0, br_ab_d};
            br_ab_d = t_ab[4];
            dab_d[4*i +: 4] = br_ab_d ? 4'(t_ab + 5'd10) : t_ab[3:0];

            t_ba = {1'b0, b_q[4*i +: 4]} - {1'b0, a_q[4*i +: 4]} - {4'b0, br_ba_d};
            br_ba_d = t_ba[4];
            dba_d[4*i +: 4] = br_ba_d ? 4'(t_ba + 5'd10) : t_ba[3:0];
        end
        res_d     = sum_d;
        res_neg_d = 1'b0;
        res_ovf_d = 1'b0;
        if (op_d == OP_ADD) begin
            res_ovf_d = carry_d;
        end else if (br_ab_d) begin
            res_d     = dba_d;
            res_neg_d = 1'b1;
        end else begin
            res_d = dab_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clr_press) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (ent_press) begin
            case (state_q)
                ENTER_A: begin
                    state_q <= ENTER_B;
                    b_q     <= '0;
                end
                ENTER_B: begin
                    state_q <= RESULT;
                    r_q     <= res_d;
                    neg_q   <= res_neg_d;
                    ovf_q   <= res_ovf_d;
                end
                default: begin
                    state_q <= ENTER_A;
                    a_q     <= r_q;
                    b_q     <= '0;
                    neg_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                end
            endcase
        end else begin
            case (state_q)
                ENTER_A: if (sld_tick_d) a_q <= a_inc_d;
                ENTER_B: if (sld_tick_d) b_q <= b_inc_d;
                default: begin
                    r_q   <= res_d;
                    neg_q <= res_neg_d;
                    ovf_q <= res_ovf_d;
                end
            endcase
        end
    end

    logic [W-1:0]          disp_val_d;
    logic [RW-1:0]         ref_cnt_q;
    logic [IW-1:0]         idx_q;
    logic [NUM_DIGITS-1:0] digit_sel_q;
    logic [6:0]            led_q;

    always_comb begin
        case (state_q)
            ENTER_A: disp_val_d = a_q;
            ENTER_B: disp_val_d = b_q;
            default: disp_val_d = r_q;
        endcase
    end

    // Enable and segments are loaded from the same index on the same edge, so they never disagree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            digit_sel_q <= ~NUM_DIGITS'(1);
            led_q       <= SEG_LUT[0];
        end else begin
            if (ref_cnt_q == REF_MAX) begin
                ref_cnt_q <= '0;
                idx_q     <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
            end
            digit_sel_q <= ~(NUM_DIGITS'(1) << idx_q);
            led_q       <= bcd_to_seg(disp_val_d[4*idx_q +: 4]);
        end
    end

    assign digit_select = digit_sel_q;
    assign led_select   = led_q;
    assign neg          = neg_q;
    assign ovf          = ovf_q;
    assign calc_state   = state_q;

endmodule

// File: tb/tb_calculator_multi.sv
// Directed bench for calculator_multi with small counter overflows so every path is reachable quickly.
module tb_calculator_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_clr = 1'b0;
    logic         btn_ent = 1'b0;
    logic [N-1:0] sld_inc = '0;
    logic         sld_arith = 1'b0;
    logic [N-1:0] digit_select;
    logic [6:0]   led_select;
    logic         neg, ovf;
    logic [1:0]   calc_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    calculator_multi #(
        .NUM_DIGITS(N), .REFRESH_OVERFLOW(10), .DB_OVERFLOW(1), .SLIDER_OVERFLOW(3)
    ) dut (
        .clk(clk), .reset(rst_n),
        .button_clr_undeb(btn_clr), .button_ent_undeb(btn_ent),
        .sld_inc(sld_inc), .sld_arith(sld_arith),
        .digit_select(digit_select), .led_select(led_select),
        .neg(neg), .ovf(ovf), .calc_state(calc_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold the masked sliders for exactly 3*n sampled edges, then let the sync pipe drain.
    task automatic slide(input logic [N-1:0] mask, input int n);
        @(negedge clk);
        sld_inc = mask;
        repeat (3 * n) @(posedge clk);
        @(negedge clk);
        sld_inc = '0;
        repeat (4) @(posedge clk);
    endtask

    // Loads a BCD value into a register that currently holds zero.
    task automatic set_value(input logic [15:0] v);
        logic [N-1:0] mask;
        for (int k = 1; k <= 9; k++) begin
            mask = '0;
            for (int i = 0; i < N; i++) if (v[4*i +: 4] >= 4'(k)) mask[i] = 1'b1;
            if (mask != '0) slide(mask, 1);
        end
    endtask

    task automatic press(input logic clr, input logic ent);
        @(negedge clk);
        btn_clr = clr;
        btn_ent = ent;
        repeat (6) @(posedge clk);
        @(negedge clk);
        btn_clr = 1'b0;
        btn_ent = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic check_display(input string tag, input logic [15:0] v);
        logic [N-1:0] target;
        logic         found;
        for (int i = 0; i < N; i++) begin
            target = ~(N'(1) << i);
            found  = 1'b0;
            for (int t = 0; t < 60 && !found; t++) begin
                @(negedge clk);
                if (digit_select == target) found = 1'b1;
            end
            check($sformatf("%s_d%0d_seen", tag, i), {31'b0, found}, 32'd1);
            if (found) check($sformatf("%s_d%0d", tag, i), {25'b0, led_select}, {25'b0, seg_tab[v[4*i +: 4]]});
        end
    endtask

    task automatic check_flags(input string tag, input logic [1:0] st, input logic n, input logic o);
        @(negedge clk);
        check({tag, "_state"}, {30'b0, calc_state}, {30'b0, st});
        check({tag, "_neg"}, {31'b0, neg}, {31'b0, n});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, o});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_state", {30'b0, calc_state}, 32'd0);
        check("rst_dsel", {28'b0, digit_select}, 32'b1110);
        check("rst_led", {25'b0, led_select}, 32'b1000000);
        check("rst_neg", {31'b0, neg}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);

        slide(4'b0001, 4);
        check_display("slide4", 16'h0004);
        slide(4'b0001, 10);
        check_display("slide_wrap10", 16'h0004);
        slide(4'b0001, 6);
        check_display("slide_wrap0", 16'h0000);

        set_value(16'h0042);
        check_display("a42", 16'h0042);
        press(1'b0, 1'b1);
        check_flags("enter_b", 2'd1, 1'b0, 1'b0);
        check_display("b_clr", 16'h0000);
        set_value(16'h0017);
        press(1'b0, 1'b1);
        check_flags("add", 2'd2, 1'b0, 1'b0);
        check_display("add59", 16'h0059);
        @(negedge clk);
        sld_arith = 1'b1;
        repeat (3) @(posedge clk);
        check_flags("sub_pos", 2'd2, 1'b0, 1'b0);
        check_display("sub25", 16'h0025);
        press(1'b0, 1'b1);
        check_flags("chain", 2'd0, 1'b0, 1'b0);
        check_display("chain25", 16'h0025);

        press(1'b1, 1'b0);
        check_flags("clr1", 2'd0, 1'b0, 1'b0);
        check_display("clr1", 16'h0000);
        set_value(16'h0017);
        press(1'b0, 1'b1);
        set_value(16'h0042);
        press(1'b0, 1'b1);
        check_flags("sub_neg", 2'd2, 1'b1, 1'b0);
        check_display("sub_neg25", 16'h0025);
        press(1'b0, 1'b1);
        check_flags("chain_neg", 2'd0, 1'b0, 1'b0);
        check_display("chain_neg25", 16'h0025);

        press(1'b1, 1'b0);
        @(negedge clk);
        sld_arith = 1'b0;
        set_value(16'h9999);
        press(1'b0, 1'b1);
        set_value(16'h0001);
        press(1'b0, 1'b1);
        check_flags("ovf", 2'd2, 1'b0, 1'b1);
        check_display("ovf0", 16'h0000);
        @(negedge clk);
        sld_arith = 1'b1;
        repeat (3) @(posedge clk);
        check_flags("sub9998", 2'd2, 1'b0, 1'b0);
        check_display("sub9998", 16'h9998);

        press(1'b1, 1'b0);
        set_value(16'h0003);
        press(1'b0, 1'b1);
        set_value(16'h0005);
        check_display("b5", 16'h0005);
        press(1'b1, 1'b1);
        check_flags("clr_ent", 2'd0, 1'b0, 1'b0);
        check_display("clr_ent", 16'h0000);

        slide(4'b0001, 2);
        check_display("pre_rst", 16'h0002);
        @(negedge clk);
        sld_inc = 4'b0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", {30'b0, calc_state}, 32'd0);
        check("mid_rst_dsel", {28'b0, digit_select}, 32'b1110);
        check("mid_rst_led", {25'b0, led_select}, 32'b1000000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sld_inc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        check_display("post_rst", 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
